// File: rtl/pipe_reg_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
package pipe_reg_pkg;
  localparam int DEF_WIDTH = 2;
  localparam int DEF_DEPTH = 2;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pipe_stage.sv
// One elastic stage: valid/data pair that loads whenever it is empty or its word moves on.
module pipe_stage #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             rnext,
  input  logic             vin,
  input  logic [WIDTH-1:0] din,
  output logic             v,
  output logic [WIDTH-1:0] d,
  output logic             rdy
);
  assign rdy = !v || rnext;

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      d <= '0;
    end else if (clr) begin
      v <= 1'b0;          // data left in place, only validity is dropped
    end else if (rdy) begin
      v <= vin;
      if (vin) d <= din;
    end
  end
endmodule

// File: rtl/pipe_reg.sv
// Parametrised elastic pipeline: ready chain, handshake and occupancy count around DEPTH stages.
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready,
  output logic [cnt_w(DEPTH)-1:0]   count
);
  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH:0]              r;
  logic                        in_fire;

  assign r[DEPTH]  = out_ready;
  assign in_ready  = r[0] && !flush && !rst;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             vin;
    logic [WIDTH-1:0] din;
    if (i == 0) begin : g_head
      assign vin = in_fire;
      assign din = in_data;
    end else begin : g_body
      assign vin = v[i-1];
      assign din = d[i-1];
    end
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .rnext (r[i+1]),
      .vin   (vin),
      .din   (din),
      .v     (v[i]),
      .d     (d[i]),
      .rdy   (r[i])
    );
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CW'(v[i]);
  end
endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg: word-level queue model, directed scenarios then random traffic.
module tb_pipe_reg;
  localparam int W = 8;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   count;

  pipe_reg #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  // Model: in-flight words with their slot position (0 = input side, D-1 = head)
  typedef struct { logic [W-1:0] data; int pos; } word_t;
  word_t        q[$];
  logic [W-1:0] head_d;
  logic         exp_ready;
  int           ntests = 0;
  int           nfail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive, check pre-edge state, advance model across the edge.
  task automatic cyc(input logic iv, input logic [W-1:0] id, input logic ordy,
                     input logic fl, input logic rs);
    logic ofire, ifire, hv;
    int   lim;
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl; rst = rs;
    #1;
    hv        = (q.size() > 0) && (q[0].pos == D-1);
    exp_ready = (q.size() < D || ordy) && !fl && !rs;
    chk("in_ready",  in_ready,  exp_ready);
    chk("out_valid", out_valid, hv);
    chk("out_data",  out_data,  head_d);
    chk("count",     count,     q.size());
    ofire = hv && ordy;
    ifire = iv && exp_ready;
    @(posedge clk);
    if (rs) begin
      q.delete(); head_d = '0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (ofire) void'(q.pop_front());
      for (int k = 0; k < q.size(); k++) begin
        lim = (k == 0) ? D : q[k-1].pos;
        if (q[k].pos + 1 < lim) q[k].pos++;
      end
      if (ifire) q.push_back('{data: id, pos: 0});
      if (q.size() > 0 && q[0].pos == D-1) head_d = q[0].data;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  logic [W-1:0] hd;
  logic         hv_hold;
  logic         riv, rord, rfl, rrs;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    head_d = '0; q.delete();

    // reset state
    idle(2);

    // back-to-back stream, unstalled
    cyc(1, 8'h11, 1, 0, 0); cyc(1, 8'h22, 1, 0, 0);
    cyc(1, 8'h33, 1, 0, 0); cyc(1, 8'h44, 1, 0, 0);
    idle(5);

    // stalled fill, fourth word held upstream, then drain
    cyc(1, 8'hA1, 0, 0, 0); cyc(1, 8'hA2, 0, 0, 0); cyc(1, 8'hA3, 0, 0, 0);
    cyc(1, 8'hA4, 0, 0, 0); cyc(1, 8'hA4, 0, 0, 0);
    cyc(1, 8'hA4, 1, 0, 0);
    idle(5);

    // full pipeline with simultaneous in/out fire
    cyc(1, 8'hC0, 0, 0, 0); cyc(1, 8'hC1, 0, 0, 0); cyc(1, 8'hC2, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(1, 8'hD0 + 8'(k), 1, 0, 0);
    idle(5);

    // flush: head word transfers, remainder discarded, nothing admitted
    cyc(1, 8'h01, 0, 0, 0); cyc(1, 8'h02, 0, 0, 0); cyc(0, 8'h00, 0, 0, 0);
    cyc(1, 8'h77, 1, 1, 0);
    idle(3);

    // reset mid-stream, then a fresh word
    cyc(1, 8'hB1, 0, 0, 0); cyc(1, 8'hB2, 0, 0, 0);
    cyc(1, 8'hB3, 0, 0, 1);
    cyc(1, 8'h5A, 1, 0, 0);
    idle(5);

    // random traffic, upstream holds data while stalled
    hv_hold = 1'b0; hd = '0;
    for (int k = 0; k < 400; k++) begin
      rord = ($urandom_range(0, 99) < 60);
      rfl  = ($urandom_range(0, 99) < 4);
      rrs  = ($urandom_range(0, 99) < 2);
      if (hv_hold) riv = 1'b1;
      else begin
        riv = ($urandom_range(0, 99) < 70);
        hd  = W'($urandom);
      end
      cyc(riv, hd, rord, rfl, rrs);
      hv_hold = riv && !exp_ready && !rfl && !rrs;
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/pipe_reg.md
Name: pipe_reg

Overview:
- Parametrised elastic register pipeline with valid/ready handshake. It is the successor to the fixed 2-bit unconditional capture register.
- Carries WIDTH-bit words through DEPTH register stages. Supports full throughput, per-stage backpressure, bubble collapsing, synchronous flush and an occupancy count.
- Sits between the input/keypad capture path and the calculator datapath, and between datapath stages where timing needs a cut.

Parameters:
- WIDTH, 2, data bits per word (>=1)
- DEPTH, 2, number of register stages (>=1)

Ports:
- clk  in  1  system clock; all state on posedge
- rst  in  1  synchronous reset, active-high
- flush  in  1  synchronous clear of all stages
- in_valid  in  1  upstream word present
- in_data  in  WIDTH  upstream word
- in_ready  out  1  pipeline accepts in_data this cycle
- out_valid  out  1  word at pipeline head
- out_data  out  WIDTH  head word
- out_ready  in  1  downstream accepts head word
- count  out  $clog2(DEPTH+1)  number of occupied stages, 0..DEPTH

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port is clk, reset port is rst.
- Per-stage state: v[i] (valid) and d[i] (data), for i = 0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 is the output.
- Ready chain (combinational):
  - r[DEPTH] = out_ready
  - r[i] = !v[i] || r[i+1]
  - in_ready = r[0] && !flush && !rst
- Transfer rules:
  - in_fire = in_valid && in_ready
  - out_fire = out_valid && out_ready
  - Stage i loads when r[i] is high. Stage 0 takes v[0] <= in_fire, d[0] <= in_data when in_fire. Stage i>0 takes v[i] <= v[i-1], d[i] <= d[i-1] when v[i-1].
  - d[i] holds its value when no word is loaded into it.
- Outputs: out_valid = v[DEPTH-1]; out_data = d[DEPTH-1]. Both are driven straight from flops, with no combinational path from in_* to out_*.
- Latency: DEPTH cycles from in_fire to out_valid when unstalled. Throughput is 1 word/cycle with out_ready held high.
- Bubble collapse: an empty stage accepts a word even when downstream is stalled. A stalled pipeline fills completely; count reaches DEPTH and in_ready drops.
- Full pipeline:
  - in_ready = out_ready, so simultaneous in_fire and out_fire keeps count at DEPTH.
  - in_ready falls in the same cycle out_ready falls (combinational).
- Empty pipeline: out_valid=0, count=0, in_ready=1.
- Handshake obligations:
  - Upstream must hold in_data stable while in_valid && !in_ready.
  - The block guarantees out_data/out_valid stable while out_valid && !out_ready. A word is never dropped or duplicated.
- flush:
  - At the next edge, all v[i] clear; d[i] unchanged.
  - in_ready=0 while flush is high, so no word enters.
  - out_fire in the flush cycle counts as a completed transfer; the remaining words are discarded.
  - count=0 the cycle after.
- rst:
  - At the edge, all v[i]=0 and all d[i]=0.
  - After reset: out_valid=0, out_data=0, count=0, in_ready=1 (with flush low).
  - Reset mid-stream discards all in-flight words. rst outranks flush.
- count = popcount(v), combinational from the valid flops.

Decomposition:
- Shared package: a count-width function (ceil log2 of DEPTH+1), plus default WIDTH/DEPTH constants for the calculator's key-code path.
- One natural sub-module, pipe_stage: a single v/d register pair with load enable, clear and ready output, instantiated DEPTH times via generate. pipe_reg owns the ready chain, the in/out handshake and the count.

Test Plan:
- DEPTH=3, WIDTH=8; rst 2 cycles, then idle -> out_valid=0, out_data=0x00, count=0, in_ready=1.
- Stream 0x11,0x22,0x33,0x44 back-to-back, out_ready=1 -> 0x11 appears on out_data exactly 3 cycles after its in_fire, one word per cycle in order, count steady at 3.
- out_ready=0, send 0xA1,0xA2,0xA3,0xA4 -> first three accepted, count=3, in_ready=0, 0xA4 held upstream. Raise out_ready -> 0xA1..0xA4 emerge in order with no gaps.
- Full pipeline, in_valid=1 and out_ready=1 simultaneously -> count stays 3, in_ready=1, every word delivered exactly once.
- Pipeline holding 0x01,0x02 with out_ready=1; pulse flush 1 cycle -> 0x01 transferred that cycle, 0x02 discarded, count=0 next cycle, no word accepted during the flush cycle.
- Assert rst mid-stream with count=2 and in_valid=1 -> next cycle out_valid=0, out_data=0x00, count=0; a later word 0x5A is delivered after 3 cycles.
